// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: shares the GMII TX byte stream feeding the RGMII TX buffer
// among P_N frame sources (0 = ARP, 1 = ICMP, 2 = UDP). One source is granted
// at a time and its bytes are forwarded with one cycle of latency. An idle gap
// is forced after every frame, oversize frames are cut at P_MAX_LEN, and a
// grant that never starts is revoked after P_START_TO cycles.
// Build option: define GMII_ARB_RR_EN for round-robin arbitration; when it is
// undefined, fixed priority applies with index 0 (ARP) highest.
`timescale 1ns/1ps
module gmii_tx_arbiter #(
  parameter int P_N        = 3,
  parameter int P_GAP      = 4,
  parameter int P_MAX_LEN  = 1526,
  parameter int P_START_TO = 255
) (
  input  logic             i_udp_stack_clk,
  input  logic             i_udp_stack_rst,
  input  logic [P_N-1:0]   i_req,
  output logic [P_N-1:0]   o_grant,
  input  logic [8*P_N-1:0] i_tx_data,
  input  logic [P_N-1:0]   i_tx_valid,
  output logic [7:0]       o_gmii_tx_data,
  output logic             o_gmii_tx_valid,
  output logic             o_busy,
  output logic             o_trunc_pulse,
  output logic             o_timeout_pulse
);

  localparam int W  = (P_N > 1) ? $clog2(P_N) : 1;
  localparam int W1 = W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [10:0] MAX_LEN    = 11'(P_MAX_LEN);
  localparam logic [15:0] START_LAST = 16'(P_START_TO - 1);
  localparam logic [15:0] GAP_LAST   = 16'(P_GAP - 1);

  logic [2:0]     state_reg, state_next;
  logic [W-1:0]   winner_reg, winner_next;
  logic [P_N-1:0] grant_reg, grant_next;
  logic [15:0]    cnt_reg, cnt_next;
  logic [10:0]    len_reg, len_next;
  logic [7:0]     data_reg, data_next;
  logic           valid_reg, valid_next;
  logic           trunc_reg, trunc_next;
  logic           timeout_reg, timeout_next;

  logic [W-1:0]   sel_idx;
  logic [7:0]     src_data [P_N];
  logic [7:0]     win_data;
  logic           win_valid;

  // Unpack the flat per-source byte bus into one lane per requester
  genvar gi;
  generate
    for (gi = 0; gi < P_N; gi++) begin : g_src
      assign src_data[gi] = i_tx_data[8*gi +: 8];
    end
  endgenerate

  assign win_data  = src_data[winner_reg];
  assign win_valid = i_tx_valid[winner_reg];

`ifdef GMII_ARB_RR_EN
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_adv;

  assign ptr_adv = (winner_reg == W'(P_N - 1)) ? '0 : winner_reg + 1'b1;

  // Round-robin pick: first requester at or after the pointer, wrapping
  always_comb begin
    logic [W:0] cand;
    sel_idx = '0;
    cand    = '0;
    for (int k = P_N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_reg} + W1'(k);
      if (cand >= W1'(P_N)) cand = cand - W1'(P_N);
      if (i_req[cand[W-1:0]]) sel_idx = cand[W-1:0];
    end
  end

  // Pointer moves past the winner once its frame has ended in any way
  always_ff @(posedge i_udp_stack_clk) begin
    if (i_udp_stack_rst) begin
      ptr_reg <= '0;
    end else if (state_reg != S_GAP && state_next == S_GAP) begin
      ptr_reg <= ptr_adv;
    end
  end
`else
  // Fixed priority pick: lowest requesting index wins
  always_comb begin
    sel_idx = '0;
    for (int k = P_N - 1; k >= 0; k--) begin
      if (i_req[k]) sel_idx = W'(k);
    end
  end
`endif

  // Next-state logic; output byte and valid default to idle (zero) each cycle
  always_comb begin
    state_next   = state_reg;
    winner_next  = winner_reg;
    grant_next   = grant_reg;
    cnt_next     = cnt_reg;
    len_next     = len_reg;
    data_next    = 8'd0;
    valid_next   = 1'b0;
    trunc_next   = 1'b0;
    timeout_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (|i_req) begin
          winner_next         = sel_idx;
          grant_next          = '0;
          grant_next[sel_idx] = 1'b1;
          cnt_next            = '0;
          len_next            = '0;
          state_next          = S_WAIT;
        end
      end
      S_WAIT: begin
        // A first byte arriving on the timeout cycle still starts the frame
        if (win_valid) begin
          data_next  = win_data;
          valid_next = 1'b1;
          len_next   = 11'd1;
          state_next = S_XFER;
        end else if (cnt_reg == START_LAST) begin
          timeout_next = 1'b1;
          grant_next   = '0;
          cnt_next     = '0;
          state_next   = S_GAP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      S_XFER: begin
        // Valid dropping exactly at the length limit is a normal end
        if (!win_valid) begin
          grant_next = '0;
          cnt_next   = '0;
          state_next = S_GAP;
        end else if (len_reg == MAX_LEN) begin
          trunc_next = 1'b1;
          state_next = S_DRAIN;
        end else begin
          data_next  = win_data;
          valid_next = 1'b1;
          len_next   = len_reg + 11'd1;
        end
      end
      S_DRAIN: begin
        if (!win_valid) begin
          grant_next = '0;
          cnt_next   = '0;
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: begin
        grant_next = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // State, grant and output registers
  always_ff @(posedge i_udp_stack_clk) begin
    if (i_udp_stack_rst) begin
      state_reg   <= S_IDLE;
      winner_reg  <= '0;
      grant_reg   <= '0;
      cnt_reg     <= '0;
      len_reg     <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      trunc_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      winner_reg  <= winner_next;
      grant_reg   <= grant_next;
      cnt_reg     <= cnt_next;
      len_reg     <= len_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      trunc_reg   <= trunc_next;
      timeout_reg <= timeout_next;
    end
  end

  assign o_grant         = grant_reg;
  assign o_gmii_tx_data  = data_reg;
  assign o_gmii_tx_valid = valid_reg;
  assign o_busy          = (state_reg != S_IDLE);
  assign o_trunc_pulse   = trunc_reg;
  assign o_timeout_pulse = timeout_reg;

endmodule
